// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter: FSM states and the
// count range (0 .. 59:59.99 in hundredths of a second).
package stopwatch_pkg;

    localparam int COUNT_W = 20;
    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(359999);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_LAP     = 2'd3
    } sw_state_t;

endpackage

// File: rtl/stopwatch_counter_button_edge.sv
// Button front end: 2-flop synchronizer followed by a registered rising-edge
// pulse (3 clk from input rise to pulse).
module button_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;
    logic valid1;
    logic valid2;
    logic armed;

    // armed is set only after sync2 has shown a real post-reset low, so a
    // button held through reset release never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            valid1 <= 1'b0;
            valid2 <= 1'b0;
            armed  <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            prev   <= sync2;
            valid1 <= 1'b1;
            valid2 <= valid1;
            armed  <= armed | (valid2 & ~sync2);
            pulse  <= sync2 & ~prev & armed;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch counting hundredths of a second with run/pause, lap freeze and
// clear, driven by three raw push-buttons.
//
//   state       | meaning
//   ------------+---------------------------------------------------
//   ST_IDLE     | cleared, waiting for start
//   ST_RUNNING  | counting, value shows live count
//   ST_PAUSED   | count and prescaler hold
//   ST_LAP      | counting continues, value shows held lap time
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_stop,
    input  logic               lap,
    input  logic               clear,
    output logic [COUNT_W-1:0] value,
    output logic               running,
    output logic               frozen
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic ss_p;
    logic lap_p;
    logic clr_p;

    sw_state_t          state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] lap_q, lap_d;
    logic               counting;
    logic               tick;

    button_edge u_ss_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (start_stop),
        .pulse (ss_p)
    );

    button_edge u_lap_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (lap),
        .pulse (lap_p)
    );

    button_edge u_clr_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (clear),
        .pulse (clr_p)
    );

    // Tick comes from the current state, so a tick on the same cycle as a
    // pause request is still counted.
    always_comb begin
        counting = (state_q == ST_RUNNING) || (state_q == ST_LAP);
        tick     = counting && (presc_q == PRESC_LAST);
    end

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        if (clr_p) begin
            presc_d = '0;
            count_d = '0;
        end else begin
            if (tick) begin
                presc_d = '0;
                count_d = (count_q == MAX_COUNT) ? '0 : count_q + 1'b1;
            end else if (counting) begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Clear beats everything; start_stop beats lap.
    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        if (clr_p) begin
            state_d = ST_IDLE;
            lap_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_p) state_d = ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (ss_p) begin
                        state_d = ST_PAUSED;
                    end else if (lap_p) begin
                        state_d = ST_LAP;
                        lap_d   = count_q;
                    end
                end
                ST_LAP: begin
                    if (ss_p) begin
                        state_d = ST_PAUSED;
                    end else if (lap_p) begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_PAUSED: begin
                    if (ss_p) state_d = ST_RUNNING;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            count_q <= '0;
            lap_q   <= '0;
            value   <= '0;
            running <= 1'b0;
            frozen  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            lap_q   <= lap_d;
            value   <= (state_q == ST_LAP) ? lap_q : count_q;
            running <= (state_d == ST_RUNNING) || (state_d == ST_LAP);
            frozen  <= (state_d == ST_LAP);
        end
    end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, count rate in Hz (one count = 10 ms); CLK_HZ SHALL be an integer multiple of TICK_HZ.
REQ-003 clk  input  1  single system clock, rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start_stop  input  1  raw button level, asynchronous to clk; each press toggles run/pause.
REQ-006 lap  input  1  raw button level, asynchronous; toggles display freeze.
REQ-007 clear  input  1  raw button level, asynchronous; zeroes the count.
REQ-008 value  output  20  elapsed time in hundredths of a second, 0..359999 (59:59.99); drives the seven-segment display stage directly.
REQ-009 running  output  1  high while counting (RUNNING or LAP).
REQ-010 frozen  output  1  high while value shows the held lap time.

Function
REQ-011 Each button input SHALL pass through a 2-flop synchronizer, then a rising-edge detector producing a 1-cycle pulse; pulse latency is 3 clk cycles from the input rising edge.
REQ-012 A prescaler SHALL count 0..(CLK_HZ/TICK_HZ - 1), advance only in RUNNING/LAP, and emit a 1-cycle tick on its terminal count, then wrap to 0.
REQ-013 The count register SHALL increment by 1 on each tick; at 359999 the next tick SHALL wrap it to 0, and counting SHALL continue.
REQ-014 States: IDLE, RUNNING, PAUSED, LAP.
REQ-015 IDLE: start_stop pulse -> RUNNING; lap pulse ignored.
REQ-016 RUNNING: start_stop pulse -> PAUSED; lap pulse -> LAP, capturing the current count into the lap register in the same cycle.
REQ-017 LAP: counting continues; lap pulse -> RUNNING; start_stop pulse -> PAUSED (freeze released).
REQ-018 PAUSED: count and prescaler hold; start_stop pulse -> RUNNING (prescaler resumes from its held value); lap pulse ignored.
REQ-019 A clear pulse in any state SHALL zero count, lap register and prescaler and go to IDLE; clear has priority over start_stop and lap pulses in the same cycle.
REQ-020 Simultaneous start_stop and lap pulses (no clear): start_stop SHALL win; lap is dropped.
REQ-021 A tick coinciding with a start_stop pulse in RUNNING SHALL still be counted.
REQ-022 value SHALL equal the lap register in LAP, otherwise the count register; value is registered and updates the cycle after the count or lap register changes.
REQ-023 running and frozen SHALL be registered decodes of the next state, valid in the same cycle as the state.

Reset
REQ-024 While rst is high at a clk edge: state IDLE, count 0, lap 0, prescaler 0, synchronizer and edge-detect flops 0, value 0, running 0, frozen 0.
REQ-025 rst asserted mid-count SHALL abandon the count with no tick emitted; a button held high through reset release SHALL NOT generate a pulse.

Structure
REQ-026 Package stopwatch_pkg SHALL hold the state enum, MAX_COUNT = 359999, and the 20-bit count width constant.
REQ-027 One sub-module, button_edge (2-flop synchronizer plus rising-edge pulse), SHALL be instantiated three times.
REQ-028 Prescaler width SHALL be $clog2(CLK_HZ/TICK_HZ).

Verification (CLK_HZ=1000, TICK_HZ=100 -> tick every 10 clk)
REQ-029 rst, then start_stop pulse, run 1000 clk -> value = 100 (+/-1 for pulse latency), running = 1.
REQ-030 Force count to 359998 while RUNNING, run 20 clk -> value steps 359999 then 0; running stays 1.
REQ-031 RUNNING at value 50, lap pulse -> frozen = 1, value holds 50 while internal count advances by 30 over 300 clk; second lap pulse -> value jumps to live count (~80).
REQ-032 start_stop pulse at value 20, wait 500 clk -> value stays 20; start_stop again -> counting resumes from 20 with no lost prescaler progress.
REQ-033 clear and start_stop asserted in the same cycle while RUNNING -> IDLE, value = 0, running = 0, frozen = 0.
REQ-034 Hold start_stop high across rst deassertion -> no pulse, stays IDLE; release and re-press -> RUNNING.
